// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - single-request issue controller between the integer pipeline and fpu_top
//
// Purpose: accepts one FP request at a time, pulses the FPU one-hot opcode,
// holds the operands, waits for the FPU result (with a watchdog), and
// presents a registered response. Flush discards the in-flight request;
// the DRAIN state waits for the FPU to go idle before the next issue.
//
// Ports:
//   sys_clk, rst          clock, synchronous active-high reset
//   req_*                 request handshake (op, x1, x2, tag)
//   flush                 discard in-flight request
//   fpu_opcode/x1/x2      issue pulse and held operands to the FPU
//   fpu_y/ovf/unf/out_valid  FPU result
//   resp_*                response handshake (y, ovf, unf, err, tag)
//   busy                  high in every state other than IDLE
module fpu_issue_ctrl #(
    parameter int TAG_W          = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [31:0]      req_x1,
    input  logic [31:0]      req_x2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic [7:0]       fpu_opcode,
    output logic [31:0]      fpu_x1,
    output logic [31:0]      fpu_x2,
    input  logic [31:0]      fpu_y,
    input  logic             fpu_ovf,
    input  logic             fpu_unf,
    input  logic             fpu_out_valid,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_y,
    output logic             resp_ovf,
    output logic             resp_unf,
    output logic             resp_err,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    logic [7:0]       cnt_q;
    logic [7:0]       opcode_q;
    logic [31:0]      x1_q;
    logic [31:0]      x2_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      resp_y_q;
    logic             resp_ovf_q;
    logic             resp_unf_q;
    logic             resp_err_q;
    logic [TAG_W-1:0] resp_tag_q;
    logic             timeout_hit;

    assign timeout_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            opcode_q   <= '0;
            x1_q       <= '0;
            x2_q       <= '0;
            tag_q      <= '0;
            resp_y_q   <= '0;
            resp_ovf_q <= 1'b0;
            resp_unf_q <= 1'b0;
            resp_err_q <= 1'b0;
            resp_tag_q <= '0;
        end else begin
            // The opcode is a single-cycle pulse, only set on the accept edge.
            opcode_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        opcode_q <= 8'(1) << req_op;
                        x1_q     <= req_x1;
                        x2_q     <= req_x2;
                        tag_q    <= req_tag;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= flush ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    // Counter stops at the compare value, so it never wraps.
                    if (!fpu_out_valid && !timeout_hit) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                    if (flush) begin
                        // A result arriving with the flush leaves the FPU idle already.
                        state_q <= fpu_out_valid ? S_IDLE : S_DRAIN;
                    end else if (fpu_out_valid) begin
                        resp_y_q   <= fpu_y;
                        resp_ovf_q <= fpu_ovf;
                        resp_unf_q <= fpu_unf;
                        resp_err_q <= 1'b0;
                        resp_tag_q <= tag_q;
                        state_q    <= S_RESP;
                    end else if (timeout_hit) begin
                        resp_y_q   <= '0;
                        resp_ovf_q <= 1'b0;
                        resp_unf_q <= 1'b0;
                        resp_err_q <= 1'b1;
                        resp_tag_q <= tag_q;
                        state_q    <= S_RESP;
                    end
                end
                S_DRAIN: begin
                    // Wait out the abandoned operation so the next issue never
                    // lands on a busy FPU.
                    if (fpu_out_valid || timeout_hit) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_RESP: begin
                    if (flush || resp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign fpu_opcode = opcode_q;
    assign fpu_x1     = x1_q;
    assign fpu_x2     = x2_q;
    assign resp_y     = resp_y_q;
    assign resp_ovf   = resp_ovf_q;
    assign resp_unf   = resp_unf_q;
    assign resp_err   = resp_err_q;
    assign resp_tag   = resp_tag_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - self-checking bench for fpu_issue_ctrl
module tb_fpu_issue_ctrl;

    localparam int TAG_W = 5;
    localparam int TO    = 64;

    logic             sys_clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [31:0]      req_x1, req_x2;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic [7:0]       fpu_opcode;
    logic [31:0]      fpu_x1, fpu_x2;
    logic [31:0]      fpu_y;
    logic             fpu_ovf, fpu_unf, fpu_out_valid;
    logic             resp_valid, resp_ready;
    logic [31:0]      resp_y;
    logic             resp_ovf, resp_unf, resp_err;
    logic [TAG_W-1:0] resp_tag;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    fpu_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(TO)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x1(req_x1), .req_x2(req_x2), .req_tag(req_tag), .flush(flush),
        .fpu_opcode(fpu_opcode), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2),
        .fpu_y(fpu_y), .fpu_ovf(fpu_ovf), .fpu_unf(fpu_unf), .fpu_out_valid(fpu_out_valid),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_y(resp_y),
        .resp_ovf(resp_ovf), .resp_unf(resp_unf), .resp_err(resp_err),
        .resp_tag(resp_tag), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Drive a request in the current (IDLE) cycle; returns in the ISSUE cycle.
    task automatic accept(input logic [2:0] op, input logic [31:0] x1, input logic [31:0] x2,
                          input logic [TAG_W-1:0] tag);
        req_valid = 1'b1; req_op = op; req_x1 = x1; req_x2 = x2; req_tag = tag;
        tick();
        req_valid = 1'b0;
        req_op = 3'($urandom); req_x1 = $urandom; req_x2 = $urandom; req_tag = TAG_W'($urandom);
    endtask

    // One full transaction: FPU result in WAIT cycle 'lat', consumer stalls 'bp' cycles.
    task automatic txn(input logic [2:0] op, input logic [31:0] x1, input logic [31:0] x2,
                       input logic [TAG_W-1:0] tag, input int lat, input int bp,
                       input logic [31:0] y, input logic ovf, input logic unf);
        logic [7:0] exp_opc;
        exp_opc = '0;
        exp_opc[op] = 1'b1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL txn_ready_before: got %b want 1", req_ready);
        end
        accept(op, x1, x2, tag);
        // ISSUE cycle: a stray out_valid here must be ignored
        fpu_out_valid = 1'($urandom_range(0, 1)); fpu_y = $urandom;
        n_checks++;
        if ({fpu_opcode, fpu_x1, fpu_x2, busy, req_ready, resp_valid} !==
            {exp_opc, x1, x2, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL txn_issue: got opc=%h x1=%h x2=%h busy=%b rdy=%b rv=%b want opc=%h x1=%h x2=%h busy=1 rdy=0 rv=0",
                     fpu_opcode, fpu_x1, fpu_x2, busy, req_ready, resp_valid, exp_opc, x1, x2);
        end
        tick();
        fpu_out_valid = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            n_checks++;
            if ({fpu_opcode, resp_valid, req_ready, busy} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL txn_wait c=%0d: got opc=%h rv=%b rdy=%b busy=%b want 00 0 0 1",
                         c, fpu_opcode, resp_valid, req_ready, busy);
            end
            if (c == lat) begin
                fpu_out_valid = 1'b1; fpu_y = y; fpu_ovf = ovf; fpu_unf = unf;
            end
            tick();
        end
        fpu_out_valid = 1'b0; fpu_y = $urandom; fpu_ovf = 1'($urandom); fpu_unf = 1'($urandom);
        for (int c = 0; c <= bp; c++) begin
            n_checks++;
            if ({resp_valid, resp_y, resp_ovf, resp_unf, resp_err, resp_tag, req_ready} !==
                {1'b1, y, ovf, unf, 1'b0, tag, 1'b0}) begin
                n_fail++;
                $display("FAIL txn_resp c=%0d: got v=%b y=%h o=%b u=%b e=%b tag=%h rdy=%b want v=1 y=%h o=%b u=%b e=0 tag=%h rdy=0",
                         c, resp_valid, resp_y, resp_ovf, resp_unf, resp_err, resp_tag, req_ready,
                         y, ovf, unf, tag);
            end
            fpu_out_valid = 1'($urandom_range(0, 1)); fpu_y = $urandom;
            resp_ready = (c == bp);
            tick();
        end
        resp_ready = 1'b0; fpu_out_valid = 1'b0;
        n_checks++;
        if ({resp_valid, req_ready, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL txn_after: got rv=%b rdy=%b busy=%b want 0 1 0", resp_valid, req_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_op = 3'd3; req_x1 = $urandom; req_x2 = $urandom;
        tick(); tick();
        n_checks++;
        if ({fpu_opcode, fpu_x1, fpu_x2, resp_valid, resp_y, resp_err, resp_tag, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got opc=%h x1=%h x2=%h rv=%b y=%h err=%b tag=%h busy=%b want all 0",
                     fpu_opcode, fpu_x1, fpu_x2, resp_valid, resp_y, resp_err, resp_tag, busy);
        end
        req_valid = 1'b0; rst = 1'b0;
        tick();
        n_checks++;
        if ({req_ready, busy} !== 2'b10) begin
            n_fail++; $display("FAIL reset_release: got rdy=%b busy=%b want 1 0", req_ready, busy);
        end
    endtask

    task automatic test_fadd();
        txn(3'd0, 32'h3F800000, 32'h40000000, 5'd7, 4, 0, 32'h40400000, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        txn(3'd2, 32'h40000000, 32'h40400000, 5'd19, 3, 5, 32'h40C00000, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        int got_at;
        accept(3'd3, $urandom, $urandom, 5'd11);
        tick();
        got_at = 0;
        for (int c = 1; c <= TO + 8; c++) begin
            if (resp_valid === 1'b1) begin
                got_at = c;
                break;
            end
            fpu_y = $urandom;
            tick();
        end
        n_checks++;
        if (got_at != TO + 1) begin
            n_fail++; $display("FAIL timeout_latency: got WAIT cycle %0d want %0d", got_at, TO + 1);
        end
        n_checks++;
        if ({resp_err, resp_y, resp_ovf, resp_unf, resp_tag} !== {1'b1, 32'h0, 1'b0, 1'b0, 5'd11}) begin
            n_fail++;
            $display("FAIL timeout_resp: got err=%b y=%h o=%b u=%b tag=%h want 1 0 0 0 0b",
                     resp_err, resp_y, resp_ovf, resp_unf, resp_tag);
        end
        resp_ready = 1'b1; tick(); resp_ready = 1'b0;
        // Result on the last permitted WAIT cycle wins over the timeout.
        txn(3'd4, $urandom, $urandom, 5'd12, TO, 1, 32'h12345678, 1'b1, 1'b0);
    endtask

    task automatic test_flush_wait();
        bit saw_resp;
        accept(3'd1, $urandom, $urandom, 5'd3);
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        saw_resp = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            n_checks++;
            if ({busy, req_ready, resp_valid} !== 3'b100) begin
                n_fail++;
                $display("FAIL flush_wait_drain c=%0d: got busy=%b rdy=%b rv=%b want 1 0 0",
                         c, busy, req_ready, resp_valid);
            end
            if (c == 3) fpu_out_valid = 1'b1;
            tick();
        end
        fpu_out_valid = 1'b0;
        n_checks++;
        if ({req_ready, resp_valid, busy} !== 3'b100) begin
            n_fail++; $display("FAIL flush_wait_idle: got rdy=%b rv=%b busy=%b want 1 0 0", req_ready, resp_valid, busy);
        end
        // Flush together with the result returns straight to IDLE.
        accept(3'd5, $urandom, $urandom, 5'd4);
        tick();
        flush = 1'b1; fpu_out_valid = 1'b1;
        tick();
        flush = 1'b0; fpu_out_valid = 1'b0;
        n_checks++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL flush_wait_with_valid: got rdy=%b rv=%b want 1 0", req_ready, resp_valid);
        end
        txn(3'd6, $urandom, $urandom, 5'd21, 2, 0, $urandom, 1'b0, 1'b1);
    endtask

    task automatic test_flush_resp_issue();
        int idle_at;
        bit saw_resp;
        accept(3'd7, $urandom, $urandom, 5'd9);
        tick();
        fpu_out_valid = 1'b1; fpu_y = $urandom;
        tick();
        fpu_out_valid = 1'b0;
        flush = 1'b1; resp_ready = 1'b1;
        tick();
        flush = 1'b0; resp_ready = 1'b0;
        n_checks++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL flush_resp: got rdy=%b rv=%b want 1 0", req_ready, resp_valid);
        end
        accept(3'd2, $urandom, $urandom, 5'd10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if ({busy, req_ready, resp_valid} !== 3'b100) begin
            n_fail++; $display("FAIL flush_issue_drain: got busy=%b rdy=%b rv=%b want 1 0 0", busy, req_ready, resp_valid);
        end
        idle_at = 0; saw_resp = 1'b0;
        for (int c = 1; c <= TO + 8; c++) begin
            if (req_ready === 1'b1) begin
                idle_at = c;
                break;
            end
            if (resp_valid === 1'b1) saw_resp = 1'b1;
            tick();
        end
        n_checks++;
        if (idle_at != TO + 1 || saw_resp) begin
            n_fail++; $display("FAIL flush_issue_timeout: got idle at %0d resp=%b want %0d 0", idle_at, saw_resp, TO + 1);
        end
    endtask

    task automatic test_reset_mid_wait();
        accept(3'd1, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd30);
        tick(); tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({fpu_opcode, fpu_x1, fpu_x2, resp_valid, resp_y, resp_ovf, resp_unf, resp_err, resp_tag, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got opc=%h x1=%h x2=%h rv=%b y=%h tag=%h busy=%b want all 0",
                     fpu_opcode, fpu_x1, fpu_x2, resp_valid, resp_y, resp_tag, busy);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_wait_ready: got %b want 1", req_ready);
        end
        fpu_out_valid = 1'b1; fpu_y = $urandom;
        tick();
        fpu_out_valid = 1'b0;
        n_checks++;
        if ({resp_valid, busy, req_ready} !== 3'b001) begin
            n_fail++; $display("FAIL reset_late_valid: got rv=%b busy=%b rdy=%b want 0 0 1", resp_valid, busy, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            txn(3'($urandom), $urandom, $urandom, TAG_W'($urandom), $urandom_range(1, 16),
                $urandom_range(0, 3), $urandom, 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_x1 = '0; req_x2 = '0; req_tag = '0;
        flush = 1'b0; fpu_y = '0; fpu_ovf = 1'b0; fpu_unf = 1'b0; fpu_out_valid = 1'b0;
        resp_ready = 1'b0;
        test_reset();
        test_fadd();
        test_backpressure();
        test_timeout();
        test_flush_wait();
        test_flush_resp_issue();
        test_back_to_back();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Core-side issue controller for `fpu_top`. It accepts one floating-point request at a time from the integer pipeline over a valid/ready handshake and encodes the operation into the FPU's one-hot `opcode` pulse. It holds the operands stable, waits for the FPU's `out_valid`, and returns the registered result, overflow and underflow flags, and destination tag over a second valid/ready handshake. A watchdog timeout and a flush path guarantee that the pipeline never deadlocks on the FPU and never issues while the FPU is still busy.

## Interface
Parameters:
- `TAG_W`, default 5: width of the destination-register tag carried with each request.
- `TIMEOUT_CYCLES`, default 64: maximum number of WAIT cycles before the request is abandoned with an error; legal range 2..255.

Ports:
- `sys_clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  1  a request is presented.
- `req_ready`  out  1  the block can accept a request; equals `(state==IDLE)`.
- `req_op`  in  3  encoded operation: 0 fadd, 1 fsub, 2 fmul, 3 fdiv, 4 fsqrt, 5 ftoi, 6 itof, 7 fabs.
- `req_x1`, `req_x2`  in  32 each  operands.
- `req_tag`  in  TAG_W  destination tag.
- `flush`  in  1  discard the in-flight request.
- `fpu_opcode`  out  8  one-hot issue pulse, bit index = `req_op`.
- `fpu_x1`, `fpu_x2`  out  32 each  registered operands.
- `fpu_y`  in  32  FPU result.
- `fpu_ovf`, `fpu_unf`  in  1 each  FPU overflow and underflow flags.
- `fpu_out_valid`  in  1  FPU result valid.
- `resp_valid`  out  1  a response is presented.
- `resp_ready`  in  1  the consumer accepts the response.
- `resp_y`  out  32  result.
- `resp_ovf`, `resp_unf`  out  1 each  result flags.
- `resp_err`  out  1  the request timed out.
- `resp_tag`  out  TAG_W  tag of the responding request.
- `busy`  out  1  asserted in every state other than IDLE.

## Operation
- The FSM has five states: IDLE, ISSUE, WAIT, RESP, and DRAIN.
- **IDLE.**
  - When `req_valid && req_ready`, latch op, x1, x2, and tag, then go to ISSUE.
  - `flush` has no effect in this state.
- **ISSUE.**
  - `fpu_opcode = 1 << op` for exactly this one cycle. `fpu_opcode` is 0 in all other states.
  - Next state is WAIT, or DRAIN if `flush` is asserted.
  - Clear the timeout counter.
- **WAIT.**
  - If `fpu_out_valid`: capture y, ovf, and unf, set err=0, and go to RESP.
  - Otherwise, if the counter equals `TIMEOUT_CYCLES-1`: set y=0, ovf=0, unf=0, err=1, and go to RESP.
  - Otherwise, increment the counter.
  - `fpu_out_valid` takes priority over the timeout in the same cycle.
  - If `flush` is asserted in WAIT:
    - with `fpu_out_valid` also asserted, go to IDLE;
    - otherwise, go to DRAIN.
- **DRAIN.**
  - The result is discarded and no response is produced.
  - Return to IDLE on `fpu_out_valid` or on timeout; the counter continues from its current value.
  - This guarantees the FPU has returned to idle before the next issue.
  - `flush` is ignored in this state.
- **RESP.**
  - `resp_valid=1`, and all `resp_*` outputs are driven from registers and held stable until the handshake completes.
  - On `resp_ready`, go to IDLE.
  - On `flush`, drop the response and go to IDLE; `flush` takes priority over `resp_ready`.
- `fpu_out_valid` is ignored in IDLE, ISSUE, and RESP.
- `fpu_x1` and `fpu_x2` hold the latched operands from ISSUE until the next accepted request.
- The counter is 8 bits wide and never wraps; it saturates at the timeout compare value.

## Timing
- **Reset.**
  - While `rst=1` at an edge, the state becomes IDLE and every registered output is cleared: `fpu_opcode`, `fpu_x1`, `fpu_x2`, `resp_*`, the counter, and `busy` all become 0.
  - `req_ready` reads 1 from the first cycle after reset is released.
- **Reset mid-operation** in any state returns to IDLE with no response.
  - The FPU shares this reset, so no drain is needed.
- **Accept-to-issue latency.**
  - A request accepted at edge T produces the `fpu_opcode` pulse in cycle T+1.
  - WAIT begins at T+2.
- **Result-to-response latency.** `fpu_out_valid` sampled high in WAIT at edge W gives `resp_valid=1` from cycle W+1.
- **Minimum initiation interval.**
  - Issue, WAIT, RESP, and IDLE take one cycle each plus the FPU latency.
  - A back-to-back request is accepted in the cycle after the response handshake.
- **Timeout.** With no `fpu_out_valid`, `resp_err` appears exactly `TIMEOUT_CYCLES` cycles after WAIT is entered.
- **Response handshake.** `resp_valid` is never deasserted without `resp_ready` or `flush`.

## Test plan
- **fadd.**
  - Stimulus: op=0, x1=0x3F800000, x2=0x40000000, tag=7; the FPU model has 4-cycle latency.
  - Required: `fpu_opcode`=0x01 for exactly one cycle, then `resp_y`=0x40400000, `resp_tag`=7, err=0, response 1 cycle after `out_valid`.
- **Backpressure.**
  - Stimulus: op=2 (fmul) with x1=0x40000000 and x2=0x40400000; hold `resp_ready` low for 5 cycles.
  - Required: `fpu_opcode`=0x04; `resp_y`=0x40C00000 stable all 5 cycles; `req_ready`=0 until the handshake completes.
- **Timeout.**
  - Stimulus: the FPU never asserts `out_valid`, TIMEOUT_CYCLES=64.
  - Required: `resp_valid` 64 cycles after WAIT entry with `resp_err`=1 and `resp_y`=0.
  - Additional case: `out_valid` arriving exactly on cycle 64 produces the real result with err=0.
- **Flush in WAIT.**
  - Stimulus: assert `flush` 2 cycles after issue; the FPU responds 3 cycles later.
  - Required: no `resp_valid`; `busy`=1 through DRAIN; `req_ready` returns 1 the cycle after `out_valid`; the next request issues normally.
- **Flush in RESP and in ISSUE.**
  - Stimulus: assert `flush` in RESP, and separately in ISSUE.
  - Required: in RESP, the response is dropped and `req_ready`=1 the next cycle; in ISSUE, the block goes to DRAIN.
- **Reset mid-WAIT.**
  - Stimulus: assert `rst` while in WAIT.
  - Required: all outputs 0 at the next edge and `req_ready`=1 after release; a later `fpu_out_valid` is ignored.
